// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: synchronizes the receiver's keycode/bit-count buses,
// detects completed bytes, decodes E0/F0 prefixes and drives a saturating duty setpoint.
module ps2_key_decoder #(
  parameter int DUTY_W      = 8,
  parameter int STEP        = 8,
  parameter int BIG_STEP    = 32,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [15:0]       keycode_i,
  input  logic [3:0]        cnt_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              key_valid_o,
  output logic [7:0]        key_code_o,
  output logic              key_ext_o,
  output logic              key_break_o
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [DUTY_W:0] STEP_X     = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W:0] BIG_STEP_X = (DUTY_W+1)'(BIG_STEP);

  // Saturating add/subtract carried out one bit wider than the duty register.
  function automatic logic [DUTY_W-1:0] sat_add(input logic [DUTY_W-1:0] a, input logic [DUTY_W:0] b);
    logic [DUTY_W:0] s;
    s = {1'b0, a} + b;
    return s[DUTY_W] ? {DUTY_W{1'b1}} : s[DUTY_W-1:0];
  endfunction

  function automatic logic [DUTY_W-1:0] sat_sub(input logic [DUTY_W-1:0] a, input logic [DUTY_W:0] b);
    logic [DUTY_W:0] s;
    s = {1'b0, a} - b;
    return s[DUTY_W] ? {DUTY_W{1'b0}} : s[DUTY_W-1:0];
  endfunction

  logic [3:0]        cnt_s1_q, cnt_s2_q, cnt_prev_q, cnt_stb_q, cnt_stb_old_q;
  logic [7:0]        kc_s1_q, kc_s2_q;
  logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
  logic              settle_busy_q, settle_busy_d;
  logic [7:0]        byte_q, byte_d;
  logic              byte_rdy_q, byte_rdy_d;
  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              emit_s, emit_ext_s, emit_brk_s;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              key_valid_q;
  logic [7:0]        key_code_q;
  logic              key_ext_q, key_brk_q;
  logic              byte_end_s;
  logic              unused_kc_hi_s;

  assign unused_kc_hi_s = ^keycode_i[15:8];
  assign byte_end_s     = (cnt_stb_q == 4'd0) && (cnt_stb_old_q == 4'd10);

  // Synchronizers plus a two-sample agreement filter on the bit counter.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt_s1_q      <= 4'd0;
      cnt_s2_q      <= 4'd0;
      cnt_prev_q    <= 4'd0;
      cnt_stb_q     <= 4'd0;
      cnt_stb_old_q <= 4'd0;
      kc_s1_q       <= 8'd0;
      kc_s2_q       <= 8'd0;
    end else begin
      cnt_s1_q      <= cnt_i;
      cnt_s2_q      <= cnt_s1_q;
      cnt_prev_q    <= cnt_s2_q;
      cnt_stb_q     <= (cnt_s2_q == cnt_prev_q) ? cnt_s2_q : cnt_stb_q;
      cnt_stb_old_q <= cnt_stb_q;
      kc_s1_q       <= keycode_i[7:0];
      kc_s2_q       <= kc_s1_q;
    end
  end

  always_comb begin
    settle_cnt_d  = settle_cnt_q;
    settle_busy_d = settle_busy_q;
    byte_d        = byte_q;
    byte_rdy_d    = 1'b0;
    if (byte_end_s) begin
      settle_cnt_d  = SW'(SETTLE_CYC);
      settle_busy_d = 1'b1;
    end else if (settle_busy_q) begin
      if (settle_cnt_q == SW'(1)) begin
        settle_cnt_d  = SW'(0);
        settle_busy_d = 1'b0;
        byte_rdy_d    = 1'b1;
        byte_d        = kc_s2_q;
      end else begin
        settle_cnt_d = settle_cnt_q - SW'(1);
      end
    end else begin
      settle_cnt_d = SW'(0);
    end
  end

  // Prefix FSM; the timeout only runs while a prefix is pending.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    emit_s     = 1'b0;
    emit_ext_s = 1'b0;
    emit_brk_s = 1'b0;
    if (byte_rdy_q) begin
      tmo_d = TW'(0);
      case (state_q)
        ST_IDLE: begin
          if (byte_q == 8'hE0)      state_d = ST_EXT;
          else if (byte_q == 8'hF0) state_d = ST_BRK;
          else                      emit_s  = 1'b1;
        end
        ST_EXT: begin
          if (byte_q == 8'hF0)      state_d = ST_EXT_BRK;
          else if (byte_q == 8'hE0) state_d = ST_EXT;
          else begin
            emit_s     = 1'b1;
            emit_ext_s = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_BRK: begin
          if ((byte_q == 8'hE0) || (byte_q == 8'hF0)) state_d = ST_BRK;
          else begin
            emit_s     = 1'b1;
            emit_brk_s = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if ((byte_q == 8'hE0) || (byte_q == 8'hF0)) state_d = ST_EXT_BRK;
          else begin
            emit_s     = 1'b1;
            emit_ext_s = 1'b1;
            emit_brk_s = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = ST_IDLE;
        tmo_d   = TW'(0);
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = TW'(0);
    end
  end

  always_comb begin
    duty_d = duty_q;
    if (emit_s && !emit_brk_s) begin
      case ({emit_ext_s, byte_q})
        9'h175:  duty_d = sat_add(duty_q, STEP_X);
        9'h172:  duty_d = sat_sub(duty_q, STEP_X);
        9'h17D:  duty_d = sat_add(duty_q, BIG_STEP_X);
        9'h17A:  duty_d = sat_sub(duty_q, BIG_STEP_X);
        9'h045:  duty_d = {DUTY_W{1'b0}};
        9'h046:  duty_d = {DUTY_W{1'b1}};
        default: duty_d = duty_q;
      endcase
    end else begin
      duty_d = duty_q;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      settle_cnt_q  <= SW'(0);
      settle_busy_q <= 1'b0;
      byte_q        <= 8'd0;
      byte_rdy_q    <= 1'b0;
      state_q       <= ST_IDLE;
      tmo_q         <= TW'(0);
      duty_q        <= {DUTY_W{1'b0}};
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'd0;
      key_ext_q     <= 1'b0;
      key_brk_q     <= 1'b0;
    end else begin
      settle_cnt_q  <= settle_cnt_d;
      settle_busy_q <= settle_busy_d;
      byte_q        <= byte_d;
      byte_rdy_q    <= byte_rdy_d;
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      duty_q        <= duty_d;
      key_valid_q   <= emit_s;
      if (emit_s) begin
        key_code_q <= byte_q;
        key_ext_q  <= emit_ext_s;
        key_brk_q  <= emit_brk_s;
      end
    end
  end

  assign duty_o      = duty_q;
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
  assign key_ext_o   = key_ext_q;
  assign key_break_o = key_brk_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a prefix/duty reference model queues expected
// key events, a monitor pops and compares them (including exact latency) on every pulse.
module tb_ps2_key_decoder;

  localparam int DUTY_W      = 8;
  localparam int STEP        = 8;
  localparam int BIG_STEP    = 32;
  localparam int SETTLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int LAT         = 2 + 2 + 1 + SETTLE_CYC + 1;
  localparam int DMAX        = (1 << DUTY_W) - 1;

  logic              clk = 1'b0;
  logic              arstn = 1'b0;
  logic [15:0]       keycode = 16'd0;
  logic [3:0]        cnt = 4'd0;
  logic [DUTY_W-1:0] duty;
  logic              key_valid;
  logic [7:0]        key_code;
  logic              key_ext;
  logic              key_break;

  ps2_key_decoder #(
    .DUTY_W(DUTY_W), .STEP(STEP), .BIG_STEP(BIG_STEP),
    .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i(clk), .arstn_i(arstn), .keycode_i(keycode), .cnt_i(cnt),
    .duty_o(duty), .key_valid_o(key_valid), .key_code_o(key_code),
    .key_ext_o(key_ext), .key_break_o(key_break)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] code;
    bit         ext;
    bit         brk;
    int         duty;
    int         t0;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: pending prefix flags and an integer duty value.
  bit m_ext = 1'b0;
  bit m_brk = 1'b0;
  int m_duty = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > DMAX) ? DMAX : v);
  endfunction

  task automatic model_byte(input logic [7:0] b, input int t0);
    exp_t e;
    if (b == 8'hE0) begin
      if (!m_brk) m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (!m_brk) begin
        if (m_ext) begin
          if (b == 8'h75)      m_duty = clamp(m_duty + STEP);
          else if (b == 8'h72) m_duty = clamp(m_duty - STEP);
          else if (b == 8'h7D) m_duty = clamp(m_duty + BIG_STEP);
          else if (b == 8'h7A) m_duty = clamp(m_duty - BIG_STEP);
        end else begin
          if (b == 8'h45)      m_duty = 0;
          else if (b == 8'h46) m_duty = DMAX;
        end
      end
      e.code = b; e.ext = m_ext; e.brk = m_brk; e.duty = m_duty; e.t0 = t0;
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    keycode = {8'($urandom), b};
    for (int i = 1; i <= 10; i++) begin
      cnt = 4'(i);
      repeat (hold) @(negedge clk);
    end
    cnt = 4'd0;
    model_byte(b, cyc);
    repeat (14) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_duty"},  int'(duty), 0);
    check({tag, "_valid"}, int'(key_valid), 0);
    check({tag, "_code"},  int'(key_code), 0);
    check({tag, "_ext"},   int'(key_ext), 0);
    check({tag, "_brk"},   int'(key_break), 0);
  endtask

  // Monitor: every key_valid pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (arstn && key_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: actual code 0x%0h ext %0d brk %0d required no event", key_code, key_ext, key_break);
        end else begin
          e = exp_q.pop_front();
          check("event_code",    int'(key_code), int'(e.code));
          check("event_ext",     int'(key_ext), int'(e.ext));
          check("event_brk",     int'(key_break), int'(e.brk));
          check("event_duty",    int'(duty), e.duty);
          check("event_latency", cyc - e.t0, LAT);
        end
      end
    end
  end

  logic [7:0] pick_tbl [9];

  initial begin
    pick_tbl = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h7D, 8'h7A, 8'h45, 8'h46, 8'h1C};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    arstn = 1'b1;

    // Abort a frame mid-way with reset, then send a full '0' frame.
    @(negedge clk);
    keycode = 16'h0033;
    for (int i = 1; i <= 5; i++) begin
      cnt = 4'(i);
      repeat (4) @(negedge clk);
    end
    #2 arstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    repeat (6) @(negedge clk);
    m_ext = 1'b0; m_brk = 1'b0; m_duty = 0;
    send_byte(8'h45, 4);

    // Up make then Up break.
    send_byte(8'hE0, 4); send_byte(8'h75, 4);
    send_byte(8'hE0, 4); send_byte(8'hF0, 4); send_byte(8'h75, 4);

    // Saturation at top, then back down to zero.
    send_byte(8'h46, 4);
    send_byte(8'hE0, 4); send_byte(8'h7D, 4);
    send_byte(8'h45, 4);
    repeat (2) begin send_byte(8'hE0, 4); send_byte(8'h75, 4); end
    repeat (3) begin send_byte(8'hE0, 4); send_byte(8'h72, 4); end

    // Prefix timeout: the lone E0 is forgotten.
    send_byte(8'hE0, 4);
    repeat (TIMEOUT_CYC + 10) @(negedge clk);
    m_ext = 1'b0; m_brk = 1'b0;
    send_byte(8'h75, 4);

    // Typematic repeats from zero.
    send_byte(8'h45, 3);
    repeat (5) begin send_byte(8'hE0, 3); send_byte(8'h75, 3); end

    // Sub-cycle glitch on cnt must not create an event.
    @(negedge clk);
    cnt = 4'd10;
    repeat (8) @(negedge clk);
    #3 cnt = 4'd0;
    #4 cnt = 4'd10;
    repeat (12) @(negedge clk);
    send_byte(8'h46, 4);

    // Randomized byte streams with random bit timing.
    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      int         idx;
      idx = int'($urandom_range(0, 9));
      if (idx == 9) b = 8'($urandom);
      else          b = pick_tbl[idx];
      send_byte(b, int'($urandom_range(3, 6)));
    end
    send_byte(8'h45, 4);

    for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_duty", int'(duty), m_duty);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
